// File: rtl/chan_mux_arb_if.sv
// Channel mux bus: producer-side channels plus the registered output handshake.
interface chan_mux_arb_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic                     cs;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic [N_CH-1:0]          in_valid;
  logic [N_CH-1:0]          in_ready;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_chan;
  logic                     out_valid;
  logic                     out_ready;

  // Master drives channels and controls; slave is the mux.
  modport master (
    output cs, mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  cs, mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/chan_mux_arb.sv
// Registered N-channel mux with direct or round-robin selection and a single
// valid/ready output register.
module chan_mux_arb #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8
) (
  input logic           clk,
  input logic           nReset,
  chan_mux_arb_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic [DATA_W-1:0] words [N_CH];
  logic              load;
  logic              grant;
  logic [SEL_W-1:0]  gnt_idx;
  logic              rr_hit;
  logic [SEL_W-1:0]  rr_idx;
  logic [SEL_W-1:0]  scan_idx;

  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  chan_q;
  logic              valid_q;
  logic [SEL_W-1:0]  last_q;

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_unpack
    assign words[i] = bus.in_data[i*DATA_W +: DATA_W];
  end

  // Output slot is free when empty or being drained this cycle.
  assign load = !valid_q || bus.out_ready;

  // Round-robin scan: first valid channel after the last one granted, with wrap.
  always_comb begin
    rr_hit   = 1'b0;
    rr_idx   = '0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      scan_idx = SEL_W'((32'(last_q) + k) % N_CH);
      if (!rr_hit && bus.in_valid[scan_idx]) begin
        rr_hit = 1'b1;
        rr_idx = scan_idx;
      end
    end
  end

  // Grant decision; out-of-range sel never grants.
  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    if (bus.cs) begin
      if (bus.mode) begin
        grant   = rr_hit;
        gnt_idx = rr_idx;
      end else if ((32'(bus.sel) < N_CH) && bus.in_valid[bus.sel]) begin
        grant   = 1'b1;
        gnt_idx = bus.sel;
      end
    end
  end

  // Ready goes only to the granted channel, and only when the slot can load.
  always_comb begin
    bus.in_ready = '0;
    if (grant && load) begin
      bus.in_ready[gnt_idx] = 1'b1;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;

  // Output register and round-robin pointer; empty slot always reads as zero.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      last_q  <= SEL_W'(N_CH - 1);
    end else if (load) begin
      if (grant) begin
        valid_q <= 1'b1;
        data_q  <= words[gnt_idx];
        chan_q  <= gnt_idx;
        if (bus.mode) begin
          last_q <= gnt_idx;
        end
      end else begin
        valid_q <= 1'b0;
        data_q  <= '0;
        chan_q  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_chan_mux_arb.sv
// Self-checking bench for chan_mux_arb: directed scenarios plus randomized traffic
// against a behavioural model of the output slot and arbitration rules.
module tb_chan_mux_arb;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic clk;
  logic nReset;

  chan_mux_arb_if #(.N_CH(N), .DATA_W(W)) bus ();

  chan_mux_arb #(.N_CH(N), .DATA_W(W)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model state: contents of the output slot and the last round-robin winner.
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic [SW-1:0] m_chan;
  int            m_last;

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = '0;
    m_last  = N - 1;
  endfunction

  function automatic bit valid_of(int c);
    return ((bus.in_valid >> c) & 1) != 0;
  endfunction

  function automatic logic [W-1:0] word_of(int g);
    logic [N*W-1:0] t;
    t = bus.in_data >> (g * W);
    return t[W-1:0];
  endfunction

  // Channel the rules would grant right now, or -1.
  function automatic int model_grant();
    if (!bus.cs) return -1;
    if (!bus.mode) return (int'(bus.sel) < N && valid_of(int'(bus.sel))) ? int'(bus.sel) : -1;
    for (int k = 1; k <= N; k++) begin
      if (valid_of((m_last + k) % N)) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    g = model_grant();
    if (g >= 0 && (!m_valid || bus.out_ready)) return N'(1) << g;
    return '0;
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    int g;
    bit ld;
    bit md;
    g  = model_grant();
    ld = !m_valid || bus.out_ready;
    md = bus.mode;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = word_of(g);
        m_chan  = SW'(g);
        if (md) m_last = g;
      end else begin
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = '0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.cs        = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    nReset = 1'b0;
    model_reset();
    #2;
    nReset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    nReset = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({bus.out_valid, bus.out_chan, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL reset_init: got v=%0b c=%0d d=%h, want all 0",
               bus.out_valid, bus.out_chan, bus.out_data);
    end
    @(posedge clk);
    #1;
    nReset = 1'b1;
    // Pending word from a round-robin grant moves the pointer to ch2.
    bus.cs = 1'b1; bus.mode = 1'b1; bus.in_valid = 4'b0100;
    bus.in_data = {8'h00, 8'h99, 8'h00, 8'h00}; bus.out_ready = 1'b0;
    #1;
    tick();
    checks++;
    if ({bus.out_valid, bus.out_chan, bus.out_data} !== {1'b1, 2'd2, 8'h99}) begin
      errors++;
      $display("FAIL reset_pending: got v=%0b c=%0d d=%h, want v=1 c=2 d=99",
               bus.out_valid, bus.out_chan, bus.out_data);
    end
    #2;
    nReset = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_chan, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL reset_async: got v=%0b c=%0d d=%h, want all 0",
               bus.out_valid, bus.out_chan, bus.out_data);
    end
    model_reset();
    bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
    bus.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    nReset = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_rr_ready: got %b, want 0001", bus.in_ready);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_chan, bus.out_data} !== {1'b1, 2'd0, 8'h11}) begin
      errors++;
      $display("FAIL reset_rr_first: got v=%0b c=%0d d=%h, want v=1 c=0 d=11",
               bus.out_valid, bus.out_chan, bus.out_data);
    end
  endtask

  task automatic test_direct();
    bus.cs = 1'b1; bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b0100;
    bus.in_data = {8'h11, 8'hA5, 8'h22, 8'h33}; bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL direct_ready: got %b, want 0100", bus.in_ready);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_chan, bus.out_data} !== {1'b1, 2'd2, 8'hA5}) begin
      errors++;
      $display("FAIL direct_out: got v=%0b c=%0d d=%h, want v=1 c=2 d=a5",
               bus.out_valid, bus.out_chan, bus.out_data);
    end
  endtask

  task automatic test_blocked();
    bus.cs = 1'b1; bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b0011;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL blocked_sel_ready: got %b, want 0000", bus.in_ready);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL blocked_sel_out: got v=%0b d=%h, want v=0 d=00",
               bus.out_valid, bus.out_data);
    end
    bus.cs = 1'b0; bus.mode = 1'b1; bus.in_valid = 4'b1111;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL blocked_cs_ready: got %b, want 0000", bus.in_ready);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL blocked_cs_out: got v=%0b d=%h, want v=0 d=00",
               bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_round_robin();
    int seq_all [5] = '{0, 1, 2, 3, 0};
    int seq_odd [4] = '{1, 3, 1, 3};
    apply_reset();
    bus.cs = 1'b1; bus.mode = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 4'b1111;
    bus.in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.out_valid, bus.out_chan, bus.out_data} !==
          {1'b1, SW'(seq_all[i]), word_of(seq_all[i])}) begin
        errors++;
        $display("FAIL rr_all[%0d]: got v=%0b c=%0d d=%h, want c=%0d",
                 i, bus.out_valid, bus.out_chan, bus.out_data, seq_all[i]);
      end
    end
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.out_valid, bus.out_chan} !== {1'b1, SW'(seq_odd[i])}) begin
        errors++;
        $display("FAIL rr_odd[%0d]: got v=%0b c=%0d, want c=%0d",
                 i, bus.out_valid, bus.out_chan, seq_odd[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.cs = 1'b1; bus.mode = 1'b0; bus.sel = 2'd1; bus.in_valid = 4'b0010;
    bus.in_data = {8'h00, 8'h00, 8'h3C, 8'h00}; bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_data = {8'h00, 8'h00, 8'h5A, 8'h00};
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b, want 0000", i, bus.in_ready);
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.out_chan, bus.out_data} !== {1'b1, 2'd1, 8'h3C}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%0b c=%0d d=%h, want v=1 c=1 d=3c",
                 i, bus.out_valid, bus.out_chan, bus.out_data);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, want 0010", bus.in_ready);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL bp_no_bubble: got v=%0b d=%h, want v=1 d=5a",
               bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_cs_drop();
    bus.cs = 1'b1; bus.mode = 1'b0; bus.sel = 2'd3; bus.in_valid = 4'b1000;
    bus.in_data = {8'h66, 8'h00, 8'h00, 8'h00}; bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.cs = 1'b0;
    tick();
    checks++;
    if ({bus.out_valid, bus.out_chan, bus.out_data} !== {1'b1, 2'd3, 8'h66}) begin
      errors++;
      $display("FAIL csdrop_hold: got v=%0b c=%0d d=%h, want v=1 c=3 d=66",
               bus.out_valid, bus.out_chan, bus.out_data);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if ({bus.out_valid, bus.out_chan, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL csdrop_drain: got v=%0b c=%0d d=%h, want all 0",
               bus.out_valid, bus.out_chan, bus.out_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.cs        = ($urandom_range(0, 9) != 0);
      bus.mode      = $urandom_range(0, 1) != 0;
      bus.sel       = SW'($urandom_range(0, N - 1));
      bus.in_valid  = N'($urandom);
      bus.in_data   = (N * W)'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (bus.in_ready !== model_ready()) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b, want %b", i, bus.in_ready, model_ready());
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.out_chan, bus.out_data} !== {m_valid, m_chan, m_data}) begin
        errors++;
        $display("FAIL rand_out[%0d]: got v=%0b c=%0d d=%h, want v=%0b c=%0d d=%h",
                 i, bus.out_valid, bus.out_chan, bus.out_data, m_valid, m_chan, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_blocked();
    test_round_robin();
    test_backpressure();
    test_cs_drop();
    apply_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/chan_mux_arb.md
Name: chan_mux_arb

Overview:
- Registered, parametrised successor to the team's combinational chip-selected output mux.
- Selects one of N_CH input channels of DATA_W bits. Selection is either direct (by sel) or by round-robin arbitration over valid channels.
- Forwards the selected word through one output register with valid/ready flow control.
- Sits between producer blocks and a shared downstream consumer.

Parameters:
- N_CH, 4, number of input channels; legal range 2..16.
- DATA_W, 8, width of each channel word.
- SEL_W, $clog2(N_CH), width of sel and out_chan (derived; do not override).

Ports:
- clk  input  1  clock; all state on rising edge.
- nReset  input  1  asynchronous active-low reset.
- cs  input  1  chip select; 0 blocks all new grants.
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SEL_W  channel index, used in direct mode.
- in_data  input  N_CH*DATA_W  flattened channel words; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; at most one bit high.
- out_data  output  DATA_W  registered selected word.
- out_chan  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_chan valid.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset: asynchronous on nReset=0.
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer last=N_CH-1, so channel 0 has first priority after reset.
  - in_ready is combinational and therefore 0 whenever out_valid=1 and out_ready=0.
- Load enable: load = !out_valid || out_ready. The output slot is empty or being drained this cycle.
- Grant (combinational, at most one channel g):
  - cs=0: no grant.
  - mode=0: grant g=sel iff sel<N_CH and in_valid[sel]=1. sel>=N_CH never grants.
  - mode=1: scan from (last+1) mod N_CH upward with wrap. g is the first channel with in_valid=1. No valid channel: no grant.
- in_ready[g] = grant && load. All other bits are 0. in_ready never depends on in_valid of other channels in mode 0.
- Transfer: on a clock edge with load=1:
  - With grant: out_data<=word g, out_chan<=g, out_valid<=1.
  - Without grant: out_valid<=0, out_data<=0, out_chan<=0. Output data reads 0 whenever not valid.
- Pointer: last<=g only on a mode=1 transfer. Direct-mode transfers leave last unchanged.
- Latency and throughput: input-to-output latency 1 cycle. With out_ready held 1, one word per cycle sustained.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_chan hold stable and all in_ready bits are 0.
- cs deassert with out_valid=1: the held word is not dropped. It stays until accepted, then out_valid falls.
- mode or sel change: takes effect on the next grant evaluation. No transfer already in the output register is affected.
- Producer rule: in_valid/in_data must stay stable until the handshake completes. The block does not latch unaccepted inputs.
- Reset mid-transfer: the word is discarded and the outputs return to reset values immediately (asynchronous).

Test Plan:
- Reset: nReset=0 while out_valid=1 with a word pending -> out_valid, out_data and out_chan all drop to 0 asynchronously; after release, first mode=1 grant with in_valid=4'b1111 goes to ch0.
- Direct select: mode=0, cs=1, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=8'hA5, out_chan=2.
- Blocked grants:
  - Direct mode, sel=2, in_valid=4'b0011 -> no grant, out_valid=0.
  - cs=0 with all channels valid -> in_ready=0, out_data=0.
- Round-robin: mode=1, in_valid=4'b1111 constant, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles. Then in_valid=4'b1010 -> alternates 1,3.
- Backpressure: out_valid=1, out_data=8'h3C, out_ready=0 for 5 cycles -> out_data stays 8'h3C and in_ready=0 throughout. out_ready=1 -> the next word loads the same edge with no bubble.
- cs drop with pending word: out_valid=1, out_ready=0, cs falls to 0 -> word held. out_ready=1 -> word accepted, next cycle out_valid=0, out_data=0.
